// File: rtl/div_hilo_ctrl_pkg.sv
// Shared definitions for the divider HI/LO controller: operand width,
// default divider latency and the controller state encoding.
package div_hilo_ctrl_pkg;

  localparam int DATA_W          = 32;
  localparam int DIV_LAT_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_hilo_ctrl_chk.sv
// Protocol checker for the divider handshake: a start pulse is never given
// while the divider is occupied, and a completion only arrives exactly
// DIV_LAT cycles after the start edge.
module div_hilo_ctrl_chk #(
  parameter int DIV_LAT = 32
) (
  input logic div_clk,
  input logic resetn,
  input logic div_req,
  input logic div_complete
);

  logic        busy_r;
  logic [31:0] cnt_r;

  // track divider occupancy and check start/complete timing
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      busy_r <= 1'b0;
      cnt_r  <= 32'd0;
    end else begin
      if (div_req) begin
        assert (!busy_r);
      end
      if (div_complete) begin
        assert (busy_r && (cnt_r == 32'(DIV_LAT)));
      end
      if (div_req) begin
        busy_r <= 1'b1;
        cnt_r  <= 32'd1;
      end else if (div_complete) begin
        busy_r <= 1'b0;
        cnt_r  <= 32'd0;
      end else if (busy_r) begin
        cnt_r  <= cnt_r + 32'd1;
      end else begin
        cnt_r  <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/div_hilo_ctrl_hilo_regs.sv
// HI/LO architectural registers. Two write sources: MTHI/MTLO from the
// pipeline and the divide commit. A commit on the same edge as an MT write
// to the same register takes priority, because the divide is the younger
// result from the register's point of view.
module div_hilo_ctrl_hilo_regs
  import div_hilo_ctrl_pkg::*;
(
  input  logic              div_clk,
  input  logic              resetn,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [DATA_W-1:0] mt_data,
  input  logic              commit_we,
  input  logic [DATA_W-1:0] commit_hi,
  input  logic [DATA_W-1:0] commit_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

  // HI register: commit beats MTHI, otherwise hold
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      hi_r <= {DATA_W{1'b0}};
    end else if (commit_we) begin
      hi_r <= commit_hi;
    end else if (mthi_we) begin
      hi_r <= mt_data;
    end else begin
      hi_r <= hi_r;
    end
  end

  // LO register: commit beats MTLO, otherwise hold
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      lo_r <= {DATA_W{1'b0}};
    end else if (commit_we) begin
      lo_r <= commit_lo;
    end else if (mtlo_we) begin
      lo_r <= mt_data;
    end else begin
      lo_r <= lo_r;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/div_hilo_ctrl.sv
// EX-stage controller for the iterative divider. Latches DIV/DIVU operands,
// pulses the divider start, stalls EX until the result is back, then commits
// remainder to HI and quotient to LO. The divider cannot be cancelled, so a
// flush while it runs parks the controller in DRAIN until the stale result
// has been discarded.
module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic              div_clk,
  input  logic              resetn,
  input  logic              es_div_valid,
  input  logic              es_div_signed,
  input  logic [DATA_W-1:0] es_x,
  input  logic [DATA_W-1:0] es_y,
  input  logic              es_flush,
  output logic              es_div_stall,
  output logic              div_req,
  output logic              div_signed,
  output logic [DATA_W-1:0] div_x,
  output logic [DATA_W-1:0] div_y,
  input  logic [DATA_W-1:0] div_s,
  input  logic [DATA_W-1:0] div_r,
  input  logic              div_complete,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [DATA_W-1:0] mt_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  div_state_e        state_r;
  div_state_e        state_nxt_s;
  logic [DATA_W-1:0] op_x_r;
  logic [DATA_W-1:0] op_y_r;
  logic              op_signed_r;
  logic [DATA_W-1:0] res_hi_r;
  logic [DATA_W-1:0] res_lo_r;
  logic              latch_op_s;
  logic              capture_s;
  logic              commit_s;
  logic              div_req_s;

  // next-state and per-state control strobes
  always_comb begin
    state_nxt_s = state_r;
    latch_op_s  = 1'b0;
    capture_s   = 1'b0;
    commit_s    = 1'b0;
    div_req_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (es_div_valid && !es_flush) begin
          latch_op_s  = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (es_flush) begin
          // divider never started, nothing to drain
          state_nxt_s = ST_IDLE;
        end else begin
          div_req_s   = 1'b1;
          state_nxt_s = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (div_complete && es_flush) begin
          state_nxt_s = ST_IDLE;
        end else if (div_complete) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (es_flush) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (!es_flush) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
        state_nxt_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div_complete) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // operand registers: loaded only in IDLE so the divider sees stable
  // x/y/signed for its whole run (it sign-corrects from the live inputs)
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      op_x_r      <= {DATA_W{1'b0}};
      op_y_r      <= {DATA_W{1'b0}};
      op_signed_r <= 1'b0;
    end else if (latch_op_s) begin
      op_x_r      <= es_x;
      op_y_r      <= es_y;
      op_signed_r <= es_div_signed;
    end else begin
      op_x_r      <= op_x_r;
      op_y_r      <= op_y_r;
      op_signed_r <= op_signed_r;
    end
  end

  // result holding registers, filled on the completion cycle
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      res_hi_r <= {DATA_W{1'b0}};
      res_lo_r <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      res_hi_r <= div_r;
      res_lo_r <= div_s;
    end else begin
      res_hi_r <= res_hi_r;
      res_lo_r <= res_lo_r;
    end
  end

  assign div_req      = div_req_s;
  assign div_x        = op_x_r;
  assign div_y        = op_y_r;
  assign div_signed   = op_signed_r;
  assign es_div_stall = es_div_valid && (state_r != ST_DONE);

  div_hilo_ctrl_hilo_regs u_hilo (
    .div_clk   (div_clk),
    .resetn    (resetn),
    .mthi_we   (mthi_we),
    .mtlo_we   (mtlo_we),
    .mt_data   (mt_data),
    .commit_we (commit_s),
    .commit_hi (res_hi_r),
    .commit_lo (res_lo_r),
    .hi        (hi),
    .lo        (lo)
  );

  div_hilo_ctrl_chk #(
    .DIV_LAT (DIV_LAT)
  ) u_chk (
    .div_clk      (div_clk),
    .resetn       (resetn),
    .div_req      (div_req),
    .div_complete (div_complete)
  );

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a behavioural 32-cycle divider.
module tb_div_hilo_ctrl;

  localparam int LAT = 32;

  logic        div_clk = 1'b0;
  logic        resetn;
  logic        es_div_valid;
  logic        es_div_signed;
  logic [31:0] es_x;
  logic [31:0] es_y;
  logic        es_flush;
  logic        es_div_stall;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        div_complete;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int complete_cnt = 0;
  logic m_busy;
  int   m_cnt;

  typedef struct {
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[6];

  always #5 div_clk = ~div_clk;

  div_hilo_ctrl #(.DIV_LAT(LAT)) dut (
    .div_clk      (div_clk),
    .resetn       (resetn),
    .es_div_valid (es_div_valid),
    .es_div_signed(es_div_signed),
    .es_x         (es_x),
    .es_y         (es_y),
    .es_flush     (es_flush),
    .es_div_stall (es_div_stall),
    .div_req      (div_req),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_s        (div_s),
    .div_r        (div_r),
    .div_complete (div_complete),
    .mthi_we      (mthi_we),
    .mtlo_we      (mtlo_we),
    .mt_data      (mt_data),
    .hi           (hi),
    .lo           (lo)
  );

  // behavioural divider: returns {remainder, quotient}
  function automatic logic [63:0] divide(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ax, ay, q, r;
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    ax = (sgn && x[31]) ? (32'd0 - x) : x;
    ay = (sgn && y[31]) ? (32'd0 - y) : y;
    q  = ax / ay;
    r  = ax % ay;
    if (sgn && (x[31] ^ y[31])) q = 32'd0 - q;
    if (sgn && x[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  // divider model: complete in the LAT-th cycle after the start edge, result from live x/y
  always @(posedge div_clk) begin
    if (!resetn) begin
      m_busy       <= 1'b0;
      m_cnt        <= 0;
      div_complete <= 1'b0;
      div_s        <= 32'd0;
      div_r        <= 32'd0;
    end else begin
      div_complete <= 1'b0;
      if (div_req) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
      end else if (m_busy) begin
        if (m_cnt == LAT - 1) begin
          div_complete   <= 1'b1;
          {div_r, div_s} <= divide(div_signed, div_x, div_y);
          m_busy         <= 1'b0;
          complete_cnt   <= complete_cnt + 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic next();
    @(posedge div_clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // cycles 0..34 of one divide, starting in the current (IDLE) cycle
  task automatic do_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic mt_at_done, input logic flush_at_done);
    es_div_valid  = 1'b1;
    es_div_signed = sgn;
    es_x          = x;
    es_y          = y;
    es_flush      = 1'b0;
    #3;
    chk1("c0_stall", es_div_stall, 1'b1);
    chk1("c0_req", div_req, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      next();
      es_x = ~x;
      es_y = ~y;
      if (c == 34) begin
        es_flush = flush_at_done;
        if (mt_at_done) begin
          mthi_we = 1'b1;
          mtlo_we = 1'b1;
          mt_data = 32'hDEADBEEF;
        end
      end
      #3;
      chk1("req", div_req, (c == 1));
      chk1("stall", es_div_stall, (c <= 33));
      if (c <= 33) begin
        chk32("div_x_hold", div_x, x);
        chk32("div_y_hold", div_y, y);
        chk1("div_signed_hold", div_signed, sgn);
      end else begin
        chk32("hi_before_commit", hi, old_hi);
        chk32("lo_before_commit", lo, old_lo);
      end
    end
  endtask

  // cycle 35: HI/LO outcome of the divide
  task automatic finish_div(input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    next();
    mthi_we  = 1'b0;
    mtlo_we  = 1'b0;
    es_flush = 1'b0;
    chk32("hi_result", hi, exp_hi);
    chk32("lo_result", lo, exp_lo);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd2,        32'd14};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'h10,       32'hF,        32'h0FFFFFFF};
    vecs[4] = '{1'b1, 32'h7FFFFFFF,   32'hFFFFFFFE, 32'd1,        32'hC0000001};
    vecs[5] = '{1'b0, 32'd5,          32'd0,        32'd5,        32'hFFFFFFFF};

    resetn = 1'b0; es_div_valid = 1'b0; es_div_signed = 1'b0; es_x = 32'd0; es_y = 32'd0;
    es_flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = 32'd0;

    // reset state
    next();
    next();
    es_div_valid = 1'b1;
    #3;
    chk1("rst_stall_follows_valid", es_div_stall, 1'b1);
    chk1("rst_req", div_req, 1'b0);
    chk32("rst_hi", hi, 32'd0);
    chk32("rst_lo", lo, 32'd0);
    chk32("rst_div_x", div_x, 32'd0);
    next();
    resetn = 1'b1;
    es_div_valid = 1'b0;
    #3;
    chk1("rst_stall_low", es_div_stall, 1'b0);

    // MTLO, MTHI, then DIVU 9/2 with HI held until commit
    next();
    mtlo_we = 1'b1; mt_data = 32'h55;
    next();
    mtlo_we = 1'b0;
    chk32("mtlo_lo", lo, 32'h55);
    chk32("mtlo_hi", hi, 32'd0);
    mthi_we = 1'b1; mt_data = 32'h1234;
    next();
    mthi_we = 1'b0;
    chk32("mthi_hi", hi, 32'h1234);
    chk32("mthi_lo", lo, 32'h55);
    do_div(1'b0, 32'd9, 32'd2, 32'h1234, 32'h55, 1'b0, 1'b0);
    finish_div(32'd1, 32'd4);

    // table: back-to-back divides, each starting in the previous one's cycle 35
    for (int i = 0; i < 6; i++) begin
      do_div(vecs[i].sgn, vecs[i].x, vecs[i].y,
             (i == 0) ? 32'd1 : vecs[i-1].exp_hi,
             (i == 0) ? 32'd4 : vecs[i-1].exp_lo, 1'b0, 1'b0);
      finish_div(vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // commit beats same-edge MTHI/MTLO
    do_div(1'b0, 32'd100, 32'd7, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0);
    finish_div(32'd2, 32'd14);

    // flush in DONE: no commit
    do_div(1'b0, 32'd50, 32'd5, 32'd2, 32'd14, 1'b0, 1'b1);
    finish_div(32'd2, 32'd14);
    es_div_valid = 1'b0;

    // flush in BUSY cycle 10, then DIVU 9/3 waits out the stale completion
    next();
    es_div_valid = 1'b1; es_div_signed = 1'b0; es_x = 32'd50; es_y = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      next();
      es_flush = (c == 10);
    end
    for (int c = 11; c <= 69; c++) begin
      next();
      es_flush = 1'b0;
      es_div_valid = (c <= 68);
      es_x = 32'd9; es_y = 32'd3;
      #3;
      chk1("drain_req", div_req, (c == 35));
      chk1("drain_stall", es_div_stall, (c <= 67));
      if (c <= 33) chk32("drain_div_x_hold", div_x, 32'd50);
      if (c == 68) chk32("drain_hi_unchanged", hi, 32'd2);
      if (c == 68) chk32("drain_lo_unchanged", lo, 32'd14);
      if (c == 69) chk32("drain_hi_result", hi, 32'd0);
      if (c == 69) chk32("drain_lo_result", lo, 32'd3);
    end

    // flush in ISSUE: divider never starts
    next();
    es_div_valid = 1'b1; es_x = 32'd20; es_y = 32'd4;
    next();
    es_flush = 1'b1;
    #3;
    chk1("issue_flush_req", div_req, 1'b0);
    next();
    es_flush = 1'b0; es_div_valid = 1'b0;
    begin
      int base;
      base = complete_cnt;
      for (int c = 0; c < 40; c++) begin
        next();
        #3;
        chk1("issue_flush_no_req", div_req, 1'b0);
      end
      checks++;
      if (complete_cnt != base) begin
        errors++;
        $display("FAIL issue_flush_divider_ran got=%0d want=%0d", complete_cnt - base, 0);
      end
    end
    chk32("issue_flush_hi", hi, 32'd0);
    chk32("issue_flush_lo", lo, 32'd3);

    // flush together with completion in BUSY: no capture, no commit
    next();
    es_div_valid = 1'b1; es_x = 32'd100; es_y = 32'd7;
    for (int c = 1; c <= 33; c++) begin
      next();
      es_flush = (c == 33);
    end
    next();
    es_flush = 1'b0; es_div_valid = 1'b0;
    #3;
    chk1("flush_complete_stall", es_div_stall, 1'b0);
    next();
    chk32("flush_complete_hi", hi, 32'd0);
    chk32("flush_complete_lo", lo, 32'd3);

    // reset at cycle 20 of a divide
    es_div_valid = 1'b1; es_x = 32'd100; es_y = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      next();
      resetn = (c != 20);
    end
    next();
    resetn = 1'b1; es_div_valid = 1'b0;
    #3;
    chk32("midrst_hi", hi, 32'd0);
    chk32("midrst_lo", lo, 32'd0);
    chk1("midrst_stall", es_div_stall, 1'b0);
    chk1("midrst_req", div_req, 1'b0);
    next();
    do_div(1'b0, 32'd9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    finish_div(32'd1, 32'd4);
    es_div_valid = 1'b0;
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
